// File: rtl/stereo_frame_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// stereo_frame_sequencer_pkg
// Shared definitions for the stereo frame sequencer and any debug logic that
// decodes its state_out port.
//   - STATE_*_ENC : 3-bit encodings driven on state_out
//   - seq_state_e : FSM state type built from those encodings
//   - is_watched(): true for states that the optional watchdog times
// ---------------------------------------------------------------------------
package stereo_frame_sequencer_pkg;

  localparam logic [2:0] STATE_IDLE_ENC    = 3'd0;
  localparam logic [2:0] STATE_CAPTURE_ENC = 3'd1;
  localparam logic [2:0] STATE_START_ENC   = 3'd2;
  localparam logic [2:0] STATE_PROCESS_ENC = 3'd3;
  localparam logic [2:0] STATE_DONE_ENC    = 3'd4;
  localparam logic [2:0] STATE_READOUT_ENC = 3'd5;

  localparam int FRAME_COUNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = STATE_IDLE_ENC,
    ST_CAPTURE = STATE_CAPTURE_ENC,
    ST_START   = STATE_START_ENC,
    ST_PROCESS = STATE_PROCESS_ENC,
    ST_DONE    = STATE_DONE_ENC,
    ST_READOUT = STATE_READOUT_ENC
  } seq_state_e;

  function automatic logic is_watched(input seq_state_e s);
    return (s == ST_CAPTURE) || (s == ST_PROCESS);
  endfunction

endpackage

// File: rtl/stereo_frame_sequencer_cam_frame_tracker.sv
// ---------------------------------------------------------------------------
// cam_frame_tracker
// Tracks one camera's progress through a frame buffer fill. The started flag
// sets on a write to address 0; the finished flag sets on a write to the last
// address (or beyond) once started is already set, so a camera that joins
// mid-frame must wrap through address 0 before its frame counts.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   active_i       : writes are only observed while high (parent collecting)
//   clear_i        : synchronous clear of both flags (wins over setting)
//   wea_i, addr_i  : camera write strobe and address
//   done_o         : finished flag OR finishing on this very cycle; lets the
//                    parent leave CAPTURE on the edge that registers the
//                    last write, independent of clear_i (no comb loop)
// ---------------------------------------------------------------------------
module cam_frame_tracker #(
  parameter int FRAME_WORDS = 12800,
  parameter int ADDR_W      = 17
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              active_i,
  input  logic              clear_i,
  input  logic              wea_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  logic started_q, started_d;
  logic finished_q, finished_d;
  logic strobe;
  logic start_hit;
  logic finish_hit;

  assign strobe     = active_i & wea_i;
  assign start_hit  = strobe && (addr_i == '0);
  assign finish_hit = strobe && started_q && (addr_i >= LAST_ADDR);
  assign done_o     = finished_q | finish_hit;

  always_comb begin
    started_d  = started_q;
    finished_d = finished_q;
    if (clear_i) begin
      started_d  = 1'b0;
      finished_d = 1'b0;
    end else begin
      if (start_hit)  started_d  = 1'b1;
      if (finish_hit) finished_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      started_q  <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      started_q  <= started_d;
      finished_q <= finished_d;
    end
  end

endmodule

// File: rtl/stereo_frame_sequencer.sv
// ---------------------------------------------------------------------------
// stereo_frame_sequencer
// Top-level sequencer for a stereo camera pipeline: gates camera BRAM writes
// while capturing, starts the stereo matcher once both frames are complete,
// counts finished frames and hands the results BRAM to a UART readout.
//
// Optional feature: define SEQ_TIMEOUT_EN to add a watchdog that aborts a
// CAPTURE or PROCESS visit lasting TIMEOUT_CYCLES cycles (error_out pulses).
// Without it, error_out is tied low and those states wait indefinitely.
//
// Ports:
//   clk_in, rst_n_in             : clock, asynchronous active-low reset
//   pacing_in                    : run enable (keep capturing frames)
//   left/right_addr_in, _wea_in  : camera write address / strobe
//   match_done_in                : matcher done pulse (used in PROCESS only)
//   readout_req_in               : level request for results readout
//   left/right_we_out            : camera strobes gated by collecting_out
//   collecting_out               : high in CAPTURE
//   new_frame_out                : one-cycle matcher start (START state)
//   readout_en_out               : high in READOUT
//   frame_count_out              : completed frames, wraps at 16 bits
//   state_out                    : current state encoding
//   error_out                    : one-cycle watchdog expiry pulse
// ---------------------------------------------------------------------------
module stereo_frame_sequencer
  import stereo_frame_sequencer_pkg::*;
#(
  parameter int FRAME_WORDS    = 12800,
  parameter int ADDR_W         = 17,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     pacing_in,
  input  logic [ADDR_W-1:0]        left_addr_in,
  input  logic [ADDR_W-1:0]        right_addr_in,
  input  logic                     left_wea_in,
  input  logic                     right_wea_in,
  input  logic                     match_done_in,
  input  logic                     readout_req_in,
  output logic                     left_we_out,
  output logic                     right_we_out,
  output logic                     collecting_out,
  output logic                     new_frame_out,
  output logic                     readout_en_out,
  output logic [FRAME_COUNT_W-1:0] frame_count_out,
  output logic [2:0]               state_out,
  output logic                     error_out
);

  seq_state_e                state_q, state_d;
  logic                      collecting_q;
  logic                      new_frame_q;
  logic                      readout_en_q;
  logic [FRAME_COUNT_W-1:0]  frame_count_q, frame_count_d;
  logic                      left_done, right_done;
  logic                      clear_flags;
  logic                      timeout_hit;

  // Flags only ever set in CAPTURE, so clearing on any exit covers abort,
  // timeout and the START hand-off in one place.
  assign clear_flags = (state_d != ST_CAPTURE);

  cam_frame_tracker #(
    .FRAME_WORDS (FRAME_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_left_tracker (
    .clk_i    (clk_in),
    .rst_n_i  (rst_n_in),
    .active_i (collecting_q),
    .clear_i  (clear_flags),
    .wea_i    (left_wea_in),
    .addr_i   (left_addr_in),
    .done_o   (left_done)
  );

  cam_frame_tracker #(
    .FRAME_WORDS (FRAME_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_right_tracker (
    .clk_i    (clk_in),
    .rst_n_i  (rst_n_in),
    .active_i (collecting_q),
    .clear_i  (clear_flags),
    .wea_i    (right_wea_in),
    .addr_i   (right_addr_in),
    .done_o   (right_done)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int                WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            error_q;

  assign timeout_hit = is_watched(state_q) && (wd_q == WD_LAST);

  // Counter restarts on every entry to a watched state (including the
  // START -> PROCESS and READOUT -> CAPTURE hand-offs).
  always_comb begin
    wd_d = '0;
    if (is_watched(state_d) && (state_d == state_q)) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= timeout_hit;
    end
  end

  assign error_out = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error_out   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pacing_in)           state_d = ST_CAPTURE;
        else if (readout_req_in) state_d = ST_READOUT;
      end
      ST_CAPTURE: begin
        if (!pacing_in)                   state_d = ST_IDLE;
        else if (timeout_hit)             state_d = ST_IDLE;
        else if (left_done && right_done) state_d = ST_START;
      end
      ST_START: begin
        state_d = ST_PROCESS;
      end
      ST_PROCESS: begin
        if (timeout_hit)        state_d = ST_IDLE;
        else if (match_done_in) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (readout_req_in) state_d = ST_READOUT;
        else if (pacing_in) state_d = ST_CAPTURE;
        else                state_d = ST_IDLE;
      end
      ST_READOUT: begin
        if (!readout_req_in) state_d = pacing_in ? ST_CAPTURE : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Count on the PROCESS -> DONE edge so the new value is visible in DONE.
  always_comb begin
    frame_count_d = frame_count_q;
    if ((state_q == ST_PROCESS) && (state_d == ST_DONE)) begin
      frame_count_d = frame_count_q + FRAME_COUNT_W'(1);
    end
  end

  // Status outputs are decoded from the next state so they line up with
  // state_out while still coming straight from flops.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_IDLE;
      collecting_q  <= 1'b0;
      new_frame_q   <= 1'b0;
      readout_en_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      collecting_q  <= (state_d == ST_CAPTURE);
      new_frame_q   <= (state_d == ST_START);
      readout_en_q  <= (state_d == ST_READOUT);
      frame_count_q <= frame_count_d;
    end
  end

  assign left_we_out     = left_wea_in  & collecting_q;
  assign right_we_out    = right_wea_in & collecting_q;
  assign collecting_out  = collecting_q;
  assign new_frame_out   = new_frame_q;
  assign readout_en_out  = readout_en_q;
  assign frame_count_out = frame_count_q;
  assign state_out       = state_q;

endmodule

// File: tb/tb_stereo_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stereo_frame_sequencer
// Directed bench for stereo_frame_sequencer with FRAME_WORDS=16 and
// TIMEOUT_CYCLES=64. Expected frame counts are queued when match_done is
// driven and compared when the DUT reaches DONE. The watchdog scenario
// follows SEQ_TIMEOUT_EN, matching however the DUT was built.
// ---------------------------------------------------------------------------
module tb_stereo_frame_sequencer;

  localparam int FW = 16;
  localparam int AW = 17;
  localparam int TO = 64;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_PROCESS = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_READOUT = 3'd5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pacing = 1'b0;
  logic [AW-1:0] la = '0;
  logic [AW-1:0] ra = '0;
  logic          lwea = 1'b0;
  logic          rwea = 1'b0;
  logic          md = 1'b0;
  logic          rr = 1'b0;

  logic          lwe, rwe, coll, nf, ren, err;
  logic [15:0]   fc;
  logic [2:0]    st;

  int checks = 0;
  int errors = 0;
  int model_count = 0;
  int exp_count[$];

  stereo_frame_sequencer #(
    .FRAME_WORDS    (FW),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .pacing_in       (pacing),
    .left_addr_in    (la),
    .right_addr_in   (ra),
    .left_wea_in     (lwea),
    .right_wea_in    (rwea),
    .match_done_in   (md),
    .readout_req_in  (rr),
    .left_we_out     (lwe),
    .right_we_out    (rwe),
    .collecting_out  (coll),
    .new_frame_out   (nf),
    .readout_en_out  (ren),
    .frame_count_out (fc),
    .state_out       (st),
    .error_out       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int lo, input int hi, input bit l, input bit r);
    for (int a = lo; a <= hi; a++) begin
      lwea = l;
      rwea = r;
      la   = AW'(a);
      ra   = AW'(a);
      step();
    end
    lwea = 1'b0;
    rwea = 1'b0;
  endtask

  // Drives match_done from PROCESS; the expected count goes on the queue now
  // and is checked when DONE shows up.
  task automatic do_match(input string tag);
    model_count = (model_count + 1) & 16'hFFFF;
    exp_count.push_back(model_count);
    md = 1'b1;
    step();
    md = 1'b0;
    chk({tag, "_state_done"}, st, S_DONE);
    if (exp_count.size() > 0) chk({tag, "_frame_count"}, fc, exp_count.pop_front());
  endtask

  initial begin
    // Reset state, with camera strobes active to prove gating.
    lwea = 1'b1;
    rwea = 1'b1;
    #2;
    chk("rst_state", st, S_IDLE);
    chk("rst_collecting", coll, 1'b0);
    chk("rst_new_frame", nf, 1'b0);
    chk("rst_readout_en", ren, 1'b0);
    chk("rst_frame_count", fc, 16'd0);
    chk("rst_error", err, 1'b0);
    chk("rst_left_we", lwe, 1'b0);
    chk("rst_right_we", rwe, 1'b0);
    lwea = 1'b0;
    rwea = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("idle_after_release", st, S_IDLE);

    // Basic frame: both cameras 0..15.
    pacing = 1'b1;
    step();
    chk("enter_capture", st, S_CAPTURE);
    chk("collecting_in_capture", coll, 1'b1);
    lwea = 1'b1;
    la   = '0;
    #1;
    chk("left_we_passes", lwe, 1'b1);
    frame(0, 14, 1'b1, 1'b1);
    chk("no_start_before_last", st, S_CAPTURE);
    frame(15, 15, 1'b1, 1'b1);
    chk("start_after_last", st, S_START);
    chk("new_frame_pulse", nf, 1'b1);
    step();
    chk("process_after_start", st, S_PROCESS);
    chk("new_frame_one_cycle", nf, 1'b0);
    do_match("f1");
    step();
    chk("done_to_capture", st, S_CAPTURE);

    // Left camera joins mid-frame and must wrap through 0.
    frame(5, 15, 1'b1, 1'b0);
    frame(0, 15, 1'b0, 1'b1);
    chk("late_left_no_start", st, S_CAPTURE);
    frame(0, 14, 1'b1, 1'b0);
    chk("late_left_still_capture", st, S_CAPTURE);
    frame(15, 15, 1'b1, 1'b0);
    chk("late_left_start", st, S_START);
    step();
    do_match("f2");
    step();
    chk("f2_back_to_capture", st, S_CAPTURE);

    // Pacing drops at address 8.
    frame(0, 7, 1'b1, 1'b1);
    lwea   = 1'b1;
    rwea   = 1'b1;
    la     = AW'(8);
    ra     = AW'(8);
    pacing = 1'b0;
    #1;
    chk("abort_cycle_left_we", lwe, 1'b1);
    step();
    chk("abort_state_idle", st, S_IDLE);
    chk("abort_collecting", coll, 1'b0);
    chk("abort_left_we_blocked", lwe, 1'b0);
    for (int a = 9; a < 14; a++) begin
      la = AW'(a);
      ra = AW'(a);
      step();
      chk("abort_no_new_frame", nf, 1'b0);
    end
    lwea = 1'b0;
    rwea = 1'b0;
    chk("abort_count_kept", fc, 16'(model_count));
    pacing = 1'b1;
    step();
    chk("reenter_capture", st, S_CAPTURE);
    frame(9, 15, 1'b1, 1'b1);
    chk("flags_cleared_after_abort", st, S_CAPTURE);

    // Readout requested through DONE.
    frame(0, 15, 1'b1, 1'b1);
    chk("f3_start", st, S_START);
    step();
    rr = 1'b1;
    do_match("f3");
    step();
    chk("readout_state", st, S_READOUT);
    chk("readout_en_high", ren, 1'b1);
    chk("readout_not_collecting", coll, 1'b0);
    lwea = 1'b1;
    la   = '0;
    #1;
    chk("readout_left_we_blocked", lwe, 1'b0);
    md = 1'b1;
    step();
    md = 1'b0;
    step();
    chk("readout_hold", st, S_READOUT);
    chk("readout_match_ignored", fc, 16'(model_count));
    lwea = 1'b0;
    rr   = 1'b0;
    step();
    chk("readout_exit_capture", st, S_CAPTURE);
    chk("readout_en_low", ren, 1'b0);

    // IDLE -> READOUT -> IDLE.
    pacing = 1'b0;
    step();
    chk("idle_again", st, S_IDLE);
    rr = 1'b1;
    step();
    chk("idle_to_readout", st, S_READOUT);
    rr = 1'b0;
    step();
    chk("readout_to_idle", st, S_IDLE);

    // Watchdog: right camera silent.
    pacing = 1'b1;
    step();
    chk("wd_capture_entry", st, S_CAPTURE);
`ifdef SEQ_TIMEOUT_EN
    begin
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < 100) begin
        lwea = (n < FW);
        la   = AW'(n);
        step();
        n++;
        if (err) seen = 1'b1;
      end
      lwea = 1'b0;
      chk("wd_error_seen", seen, 1'b1);
      chk("wd_error_latency", n, TO);
      chk("wd_state_idle", st, S_IDLE);
      chk("wd_count_unchanged", fc, 16'(model_count));
      pacing = 1'b0;
      step();
      chk("wd_error_one_cycle", err, 1'b0);
    end
`else
    for (int n = 0; n < 70; n++) begin
      lwea = (n < FW);
      la   = AW'(n);
      step();
      if (err !== 1'b0) chk("no_wd_error_low", err, 1'b0);
    end
    lwea = 1'b0;
    chk("no_wd_wait_capture", st, S_CAPTURE);
    chk("no_wd_error_tied", err, 1'b0);
    pacing = 1'b0;
    step();
    chk("no_wd_abort_idle", st, S_IDLE);
`endif

    // Reset while in PROCESS.
    pacing = 1'b1;
    step();
    frame(0, 15, 1'b1, 1'b1);
    step();
    chk("pre_reset_process", st, S_PROCESS);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", st, S_IDLE);
    chk("async_rst_count", fc, 16'd0);
    chk("async_rst_collecting", coll, 1'b0);
    chk("async_rst_new_frame", nf, 1'b0);
    chk("async_rst_readout_en", ren, 1'b0);
    chk("async_rst_error", err, 1'b0);
    model_count = 0;
    pacing = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    md = 1'b1;
    step();
    md = 1'b0;
    step();
    chk("stray_match_count", fc, 16'd0);
    chk("stray_match_state", st, S_IDLE);
    pacing = 1'b1;
    step();
    frame(1, 15, 1'b1, 1'b1);
    chk("fresh_addr0_required", st, S_CAPTURE);
    frame(0, 15, 1'b1, 1'b1);
    chk("post_reset_start", st, S_START);

    chk("scoreboard_drained", exp_count.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
